// File: rtl/adc_scan_seq_pkg.sv
// Shared types and derivations for the ADC scan sequencer: FSM states,
// counter sizing and the idle levels of the ADC control pins.
package adc_scan_pkg;

    typedef enum logic [3:0] {
        S_OFF      = 4'd0,
        S_BOOT     = 4'd1,
        S_IDLE     = 4'd2,
        S_CONV     = 4'd3,
        S_WAIT_EOC = 4'd4,
        S_SEL      = 4'd5,
        S_RD       = 4'd6,
        S_CAPTURE  = 4'd7,
        S_RELEASE  = 4'd8,
        S_NEXT     = 4'd9
    } state_e;

    localparam logic CONVST_IDLE = 1'b1;
    localparam logic RD_N_IDLE   = 1'b1;
    localparam logic CS_N_IDLE   = 1'b1;
    localparam logic PD_OFF      = 1'b0;

    function automatic int boot_cycles(input int clk_mhz, input int pd_us);
        return clk_mhz * pd_us;
    endfunction

    // Width able to hold 0 .. limit-1; never below one bit.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adc_scan_seq_if.sv
// Bundle of ADC pins, control inputs and result outputs of adc_scan_seq.
// master = sequencer side, slave = ADC / sensor-logic side.
interface adc_scan_seq_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
);
    logic                     pwr;
    logic                     start;
    logic                     cont;
    logic [NUM_CH-1:0]        ch_mask;
    logic [DATA_W-1:0]        data_in;
    logic                     eoc;
    logic [ADDR_W-1:0]        addr;
    logic                     convst;
    logic                     pd;
    logic                     rd_n;
    logic                     cs_n;
    logic                     ready;
    logic                     sample_valid;
    logic [ADDR_W-1:0]        sample_ch;
    logic [DATA_W-1:0]        sample_data;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic                     frame_done;
    logic                     timeout_err;

    modport master (
        input  pwr, start, cont, ch_mask, data_in, eoc,
        output addr, convst, pd, rd_n, cs_n, ready, sample_valid,
               sample_ch, sample_data, ch_data, frame_done, timeout_err
    );

    modport slave (
        output pwr, start, cont, ch_mask, data_in, eoc,
        input  addr, convst, pd, rd_n, cs_n, ready, sample_valid,
               sample_ch, sample_data, ch_data, frame_done, timeout_err
    );
endinterface

// File: rtl/adc_scan_seq_ch_pick.sv
// Finds the lowest enabled channel above cur (or at/above cur when incl=1).
module adc_ch_pick #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 2
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [ADDR_W-1:0] cur,
    input  logic              incl,
    output logic              found,
    output logic [ADDR_W-1:0] nxt
);

    // Descending scan so the last hit written is the lowest qualifying channel.
    always_comb begin
        found = 1'b0;
        nxt   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))))) begin
                found = 1'b1;
                nxt   = ADDR_W'(i);
            end else begin
                found = found;
                nxt   = nxt;
            end
        end
    end

endmodule

// File: rtl/adc_scan_seq.sv
// Frame sequencer for a parallel-output multi-channel ADC: power-up wait,
// masked ascending channel scan, result bank and EOC timeout handling.
module adc_scan_seq
    import adc_scan_pkg::*;
#(
    parameter int CLK_FREQ    = 50,
    parameter int PD_US       = 25,
    parameter int NUM_CH      = 3,
    parameter int ADDR_W      = 2,
    parameter int DATA_W      = 8,
    parameter int RD_CYC      = 2,
    parameter int EOC_TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset,
    adc_scan_seq_if.master bus
);

    localparam int BOOT_CYC = boot_cycles(CLK_FREQ, PD_US);
    localparam int CNT_W    = max_int(max_int(cnt_width(BOOT_CYC), cnt_width(EOC_TIMEOUT)),
                                      cnt_width(RD_CYC));

    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYC - 1);
    localparam logic [CNT_W-1:0] EOC_LAST  = CNT_W'(EOC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_CYC - 1);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NUM_CH-1:0]        mask_q, mask_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic                     convst_q, convst_d;
    logic                     pd_q, pd_d;
    logic                     rd_n_q, rd_n_d;
    logic                     cs_n_q, cs_n_d;
    logic                     ready_q, ready_d;
    logic                     sample_valid_q, sample_valid_d;
    logic [ADDR_W-1:0]        sample_ch_q, sample_ch_d;
    logic [DATA_W-1:0]        sample_data_q, sample_data_d;
    logic [NUM_CH*DATA_W-1:0] ch_data_q, ch_data_d;
    logic                     frame_done_q, frame_done_d;
    logic                     timeout_err_q, timeout_err_d;

    logic                     low_found_s;
    logic [ADDR_W-1:0]        low_ch_s;
    logic                     nxt_found_s;
    logic [ADDR_W-1:0]        nxt_ch_s;

    adc_ch_pick #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) u_pick_low (
        .mask  (bus.ch_mask),
        .cur   ({ADDR_W{1'b0}}),
        .incl  (1'b1),
        .found (low_found_s),
        .nxt   (low_ch_s)
    );

    adc_ch_pick #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) u_pick_next (
        .mask  (mask_q),
        .cur   (addr_q),
        .incl  (1'b0),
        .found (nxt_found_s),
        .nxt   (nxt_ch_s)
    );

    // Next-state and next-output computation; pins follow the upcoming state.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mask_d         = mask_q;
        addr_d         = addr_q;
        sample_valid_d = 1'b0;
        sample_ch_d    = sample_ch_q;
        sample_data_d  = sample_data_q;
        ch_data_d      = ch_data_q;
        frame_done_d   = 1'b0;
        timeout_err_d  = timeout_err_q;

        case (state_q)
            S_OFF: begin
                if (bus.pwr) begin
                    state_d = S_BOOT;
                    cnt_d   = '0;
                end else begin
                    state_d = S_OFF;
                end
            end
            S_BOOT: begin
                if (cnt_q == BOOT_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                // A frame request wins over a power-down in the same cycle.
                if (bus.start) begin
                    if (low_found_s) begin
                        mask_d        = bus.ch_mask;
                        addr_d        = low_ch_s;
                        timeout_err_d = 1'b0;
                        state_d       = S_CONV;
                    end else begin
                        frame_done_d = 1'b1;
                    end
                end else if (!bus.pwr) begin
                    state_d = S_OFF;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CONV: begin
                state_d = S_WAIT_EOC;
                cnt_d   = '0;
            end
            S_WAIT_EOC: begin
                if (!bus.eoc) begin
                    state_d = S_SEL;
                end else if (cnt_q == EOC_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SEL: begin
                state_d = S_RD;
                cnt_d   = '0;
            end
            S_RD: begin
                if (cnt_q == RD_LAST) begin
                    state_d        = S_CAPTURE;
                    sample_valid_d = 1'b1;
                    sample_ch_d    = addr_q;
                    sample_data_d  = bus.data_in;
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (addr_q == ADDR_W'(k)) begin
                            ch_data_d[k*DATA_W +: DATA_W] = bus.data_in;
                        end else begin
                            ch_data_d[k*DATA_W +: DATA_W] = ch_data_q[k*DATA_W +: DATA_W];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (nxt_found_s) begin
                    addr_d  = nxt_ch_s;
                    state_d = S_CONV;
                end else begin
                    frame_done_d = 1'b1;
                    if (bus.cont && bus.pwr) begin
                        mask_d = bus.ch_mask;
                        if (low_found_s) begin
                            addr_d  = low_ch_s;
                            state_d = S_CONV;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_OFF;
            end
        endcase

        convst_d = (state_d == S_CONV) ? ~CONVST_IDLE : CONVST_IDLE;
        rd_n_d   = (state_d == S_RD) ? ~RD_N_IDLE : RD_N_IDLE;
        cs_n_d   = ((state_d == S_SEL) || (state_d == S_RD) || (state_d == S_CAPTURE))
                   ? ~CS_N_IDLE : CS_N_IDLE;
        pd_d     = (state_d == S_OFF) ? PD_OFF : ~PD_OFF;
        ready_d  = (state_d == S_IDLE);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_OFF;
            cnt_q          <= '0;
            mask_q         <= '0;
            addr_q         <= '0;
            convst_q       <= CONVST_IDLE;
            pd_q           <= PD_OFF;
            rd_n_q         <= RD_N_IDLE;
            cs_n_q         <= CS_N_IDLE;
            ready_q        <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_ch_q    <= '0;
            sample_data_q  <= '0;
            ch_data_q      <= '0;
            frame_done_q   <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mask_q         <= mask_d;
            addr_q         <= addr_d;
            convst_q       <= convst_d;
            pd_q           <= pd_d;
            rd_n_q         <= rd_n_d;
            cs_n_q         <= cs_n_d;
            ready_q        <= ready_d;
            sample_valid_q <= sample_valid_d;
            sample_ch_q    <= sample_ch_d;
            sample_data_q  <= sample_data_d;
            ch_data_q      <= ch_data_d;
            frame_done_q   <= frame_done_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign bus.addr         = addr_q;
    assign bus.convst       = convst_q;
    assign bus.pd           = pd_q;
    assign bus.rd_n         = rd_n_q;
    assign bus.cs_n         = cs_n_q;
    assign bus.ready        = ready_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.sample_ch    = sample_ch_q;
    assign bus.sample_data  = sample_data_q;
    assign bus.ch_data      = ch_data_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.timeout_err  = timeout_err_q;

endmodule
